// File: rtl/glcd_refresh_engine.sv
// Refresh engine for a multi-controller KS0108-class graphic LCD: sequences the panel's
// power-on reset and init, then streams masked pages from a synchronous frame-buffer RAM.
module glcd_refresh_engine #(
    parameter int NUM_CHIPS = 2,
    parameter int PAGES     = 8,
    parameter int COLS      = 64,
    parameter int RST_CYC   = 16,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 4,
    parameter int HOLD_CYC  = 2,
    localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int YW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int AW = CW + PW + YW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [PAGES-1:0]     page_mask_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AW-1:0]        addr_o,
    input  logic [7:0]           data_i,
    output logic [7:0]           db_o,
    output logic                 dori_o,
    output logic [NUM_CHIPS-1:0] cs_o,
    output logic                 en_o,
    output logic                 rw_o,
    output logic                 rst_o
);
    localparam int TX_LEN = SETUP_CYC + EN_CYC + HOLD_CYC;
    localparam int PHW    = $clog2(TX_LEN);
    localparam int RCW    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [3:0] {
        S_RST_LOW, S_RST_HIGH, S_INIT, S_IDLE, S_PAGE_CMD, S_COL_CMD, S_DATA, S_EMPTY, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PHW-1:0]       ph_q, ph_d;
    logic [RCW-1:0]       rcnt_q, rcnt_d;
    logic [CW-1:0]        chip_q, chip_d;
    logic [PW-1:0]        page_q, page_d;
    logic [YW-1:0]        col_q, col_d;
    logic                 step_q, step_d;
    logic [PAGES-1:0]     mask_q, mask_d;
    logic                 sync1_q, sync2_q, queued_q, queued_d;
    logic                 rst_n_q, rst_n_d, en_q, en_d, dori_q, dori_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]           db_q, db_d;
    logic [NUM_CHIPS-1:0] cs_q, cs_d;
    logic [AW-1:0]        addr_q, addr_d;

    logic                 start_edge, tx_state, tx_last, launch, l_data;
    logic [7:0]           l_cmd;
    logic [PW:0]          np;

    // Lowest set page at or above 'from'; MSB of the result flags whether one exists.
    function automatic logic [PW:0] next_page(input logic [PAGES-1:0] m, input int from);
        logic [PW:0] r;
        r = '0;
        for (int p = PAGES - 1; p >= 0; p--) begin
            if (p >= from && m[p]) r = {1'b1, PW'(p)};
        end
        return r;
    endfunction

    assign start_edge = sync1_q & ~sync2_q;
    assign tx_state   = (state_q == S_INIT) || (state_q == S_PAGE_CMD) ||
                        (state_q == S_COL_CMD) || (state_q == S_DATA);
    assign tx_last    = (ph_q == PHW'(TX_LEN - 1));

    always_comb begin
        state_d  = state_q;  ph_d   = ph_q;   rcnt_d = rcnt_q; chip_d = chip_q;
        page_d   = page_q;   col_d  = col_q;  step_d = step_q; mask_d = mask_q;
        queued_d = queued_q; rst_n_d = rst_n_q; en_d = en_q;   dori_d = dori_q;
        db_d     = db_q;     cs_d   = cs_q;   addr_d = addr_q; busy_d = busy_q;
        done_d   = 1'b0;
        launch   = 1'b0;     l_data = 1'b0;   l_cmd  = '0;     np     = '0;

        if (start_edge) queued_d = 1'b1;

        case (state_q)
            S_RST_LOW: begin
                if (rcnt_q == RCW'(RST_CYC - 1)) begin
                    rcnt_d  = '0;
                    rst_n_d = 1'b1;
                    state_d = S_RST_HIGH;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_RST_HIGH: begin
                if (rcnt_q == RCW'(RST_CYC - 1)) begin
                    state_d = S_INIT;
                    chip_d  = '0;
                    step_d  = 1'b0;
                    launch  = 1'b1;
                    l_cmd   = 8'h3F;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_INIT: begin
                if (tx_last) begin
                    if (!step_q) begin
                        step_d = 1'b1;
                        launch = 1'b1;
                        l_cmd  = 8'hC0;
                    end else if (chip_q == CW'(NUM_CHIPS - 1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        chip_d = chip_q + 1'b1;
                        step_d = 1'b0;
                        launch = 1'b1;
                        l_cmd  = 8'h3F;
                    end
                end
            end
            S_IDLE: begin
                if (start_edge || queued_q) begin
                    queued_d = 1'b0;
                    mask_d   = page_mask_i;
                    busy_d   = 1'b1;
                    chip_d   = '0;
                    np       = next_page(page_mask_i, 0);
                    if (np[PW]) begin
                        page_d  = np[PW-1:0];
                        col_d   = '0;
                        state_d = S_PAGE_CMD;
                        launch  = 1'b1;
                        l_cmd   = 8'hB8 | 8'(np[PW-1:0]);
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            S_PAGE_CMD: begin
                if (tx_last) begin
                    state_d = S_COL_CMD;
                    launch  = 1'b1;
                    l_cmd   = 8'h40;
                end
            end
            S_COL_CMD: begin
                if (tx_last) begin
                    state_d = S_DATA;
                    launch  = 1'b1;
                    l_data  = 1'b1;
                end
            end
            S_DATA: begin
                if (tx_last) begin
                    if (col_q != YW'(COLS - 1)) begin
                        col_d  = col_q + 1'b1;
                        launch = 1'b1;
                        l_data = 1'b1;
                    end else begin
                        // Unset pages cost no cycles: jump straight to the next set one.
                        np = next_page(mask_q, int'(page_q) + 1);
                        if (!np[PW] && chip_q != CW'(NUM_CHIPS - 1)) begin
                            chip_d = chip_q + 1'b1;
                            np     = next_page(mask_q, 0);
                        end
                        if (np[PW]) begin
                            page_d  = np[PW-1:0];
                            col_d   = '0;
                            state_d = S_PAGE_CMD;
                            launch  = 1'b1;
                            l_cmd   = 8'hB8 | 8'(np[PW-1:0]);
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            S_EMPTY: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_RST_LOW;
        endcase

        // Bus lines change only when a new transaction launches; data bytes arrive one
        // cycle after the address, so they are captured at the end of setup cycle 1.
        if (launch) begin
            ph_d   = '0;
            en_d   = 1'b0;
            cs_d   = NUM_CHIPS'(1) << chip_d;
            dori_d = l_data;
            if (l_data) addr_d = {chip_d, page_d, col_d};
            else        db_d   = l_cmd;
        end else if (tx_state && !tx_last) begin
            ph_d = ph_q + 1'b1;
            en_d = (ph_d >= PHW'(SETUP_CYC)) && (ph_d < PHW'(SETUP_CYC + EN_CYC));
            if (dori_q && ph_q == PHW'(1)) db_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST_LOW; ph_q <= '0; rcnt_q <= '0; chip_q <= '0; page_q <= '0;
            col_q <= '0; step_q <= 1'b0; mask_q <= '0; sync1_q <= 1'b0; sync2_q <= 1'b0;
            queued_q <= 1'b0; rst_n_q <= 1'b0; en_q <= 1'b0; dori_q <= 1'b0; db_q <= '0;
            cs_q <= '0; addr_q <= '0; busy_q <= 1'b1; done_q <= 1'b0;
        end else begin
            state_q <= state_d; ph_q <= ph_d; rcnt_q <= rcnt_d; chip_q <= chip_d; page_q <= page_d;
            col_q <= col_d; step_q <= step_d; mask_q <= mask_d; sync1_q <= start_i;
            sync2_q <= sync1_q; queued_q <= queued_d; rst_n_q <= rst_n_d; en_q <= en_d;
            dori_q <= dori_d; db_q <= db_d; cs_q <= cs_d; addr_q <= addr_d;
            busy_q <= busy_d; done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign addr_o = addr_q;
    assign db_o   = db_q;
    assign dori_o = dori_q;
    assign cs_o   = cs_q;
    assign en_o   = en_q;
    assign rw_o   = 1'b0;
    assign rst_o  = rst_n_q;
endmodule

// File: doc/glcd_refresh_engine.md
Name: glcd_refresh_engine

Overview:
- Parametrised successor to the dual-chip graphic LCD driver.
- Drives a multi-controller KS0108-class panel: a data/instruction select, a read/write line, an enable strobe and one chip-select per controller.
- Reads a page-organised frame buffer through a synchronous RAM port with 1-cycle read latency.
- Adds the following on top of the original driver:
  - power-on init sequencing;
  - programmable enable timing;
  - per-page partial refresh via a mask;
  - one-deep start queuing;
  - busy/done status.

Parameters:
- NUM_CHIPS, 2, number of panel controllers (1..4); each controller drives COLS columns.
- PAGES, 8, pages per controller (1..8); one page is 8 pixel rows.
- COLS, 64, columns per controller (1..64).
- RST_CYC, 16, cycles rst_o is held low after reset.
- SETUP_CYC, 2, cycles bus lines are stable before en_o rises (minimum 2).
- EN_CYC, 4, en_o high cycles per transaction (minimum 1).
- HOLD_CYC, 2, cycles en_o is low after its falling edge before the next transaction (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  refresh request; the block acts on a rising edge.
- page_mask_i  in  PAGES  pages to refresh; sampled on the accepted start edge.
- busy_o  out  1  high from the start of init, or from refresh acceptance, until done.
- done_o  out  1  one-cycle pulse when a refresh completes.
- addr_o  out  CW+PW+YW  frame buffer address {chip, page, col}.
  - CW = clog2(NUM_CHIPS), min 1; PW = clog2(PAGES), min 1; YW = clog2(COLS).
- data_i  in  8  frame buffer byte, valid the cycle after addr_o.
- db_o  out  8  panel data bus.
- dori_o  out  1  1 = display data, 0 = instruction.
- cs_o  out  NUM_CHIPS  one-hot controller select, active high.
- en_o  out  1  panel enable strobe.
- rw_o  out  1  panel R/W; tied to 0 (write only).
- rst_o  out  1  panel reset, active low.

Behaviour:
- Reset is synchronous, active-high, and takes effect from any state, including mid-transaction.
- Reset values:
  - rst_o=0, en_o=0, rw_o=0, dori_o=0;
  - db_o=0, cs_o=0, addr_o=0;
  - busy_o=1, done_o=0.
- Reset also clears the queued-start flag and the start edge history.
- start_i passes through a 2-flop synchroniser. An edge is synchroniser stage 1 high while stage 2 is low.

Transaction (TX):
- Total length SETUP_CYC+EN_CYC+HOLD_CYC cycles.
- addr_o, dori_o and cs_o change only in the first setup cycle.
- For instruction TX, db_o is also loaded in the first setup cycle.
- For data TX, db_o is loaded from data_i at the end of setup cycle 1.
- en_o is high for exactly EN_CYC cycles.
- All bus outputs are held constant through en_o high and hold.

State machine: RST_WAIT -> INIT -> IDLE -> PAGE_CMD -> COL_CMD -> DATA -> (next page/chip) -> DONE -> IDLE.
- RST_WAIT: rst_o=0 for RST_CYC cycles, then rst_o=1 and a further RST_CYC wait.
- INIT: for chip 0..NUM_CHIPS-1 in order, two instruction TXs: 0x3F (display on), then 0xC0 (start line 0). Then go to IDLE with busy_o=0. No done_o pulse.
- IDLE: on an accepted start edge, latch page_mask_i and set busy_o=1 next cycle. If the mask is all-zero, go straight to DONE.
- Refresh order:
  - chips ascending; within a chip, set pages ascending; unset pages are skipped with zero cycles spent;
  - per page: instruction 0xB8|page, then instruction 0x40, then COLS data TXs;
  - data TX col = 0..COLS-1, with addr_o = {chip, page, col}.
- DONE: done_o=1 for one cycle and busy_o=0 in the same cycle.
  - If a start edge arrived while busy (queued flag set), the next refresh is accepted in the cycle after DONE, using page_mask_i sampled at that time.
  - Further edges while busy are dropped; the queue is one deep.
- Start edges during RST_WAIT/INIT set the queued flag. That refresh runs after INIT completes.
- Counters wrap exactly at PAGES-1 and COLS-1; they never index beyond the parameter range.
- rst_o stays 1 after RST_WAIT until the next rst.

Test Plan:
- Reset, defaults:
  - rst_o low for 16 cycles, then high;
  - 4 instruction TXs in order cs=01:0x3F, cs=01:0xC0, cs=10:0x3F, cs=10:0xC0;
  - each TX has en_o high exactly 4 cycles, TX period 8;
  - then busy_o=0 with no done_o.
- Full refresh, mask=0xFF:
  - 2*8*(2+64)=1056 TXs, 8448 cycles from acceptance to done_o;
  - the 3rd TX of chip1/page3 has addr_o=0b1_011_000000 and db_o equal to the RAM content at that address;
  - dori_o=1 on data TX only.
- Partial refresh, mask=0x05: per chip only 0xB8 and 0xBA page commands; 264 TXs total; done_o single pulse.
- Mask=0x00: done_o pulses within 3 cycles of the edge; en_o never rises.
- Queuing:
  - two start edges during a busy refresh: exactly one extra refresh follows, starting the cycle after done_o;
  - start_i held high gives no retrigger.
- Mid-refresh reset:
  - assert rst during en_o high in a data TX;
  - next cycle en_o=0, cs_o=0, busy_o=1, rst_o=0;
  - the full init sequence reruns and the queued start is lost.
